pcie_h2c_framer: RTL and testbench

PCIE_H2C_FRAMER -- requirements
Module: pcie_h2c_framer

---
 rtl/pcie_h2c_framer.sv | 144 ++++++++++++++
 tb/tb_pcie_h2c_framer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_h2c_framer.sv
// H2C framer: strips a magic/length/opcode header beat and forwards the payload through one register stage.
// Optional statistics counters are built only when PCIE_H2C_FRAMER_STATS_EN is defined.
module pcie_h2c_framer #(
   parameter logic [15:0] MAGIC   = 16'h4B56,
   parameter int          MAX_LEN = 4096
) (
   input  logic         axi_aclk,
   input  logic         axi_aresetn,
   input  logic [255:0] s_axis_tdata,
   input  logic [31:0]  s_axis_tkeep,
   input  logic         s_axis_tlast,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   output logic [255:0] m_axis_tdata,
   output logic [31:0]  m_axis_tkeep,
   output logic         m_axis_tlast,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic [15:0]  m_axis_tuser,
   output logic         m_axis_terr,
   output logic [31:0]  stat_frames,
   output logic [31:0]  stat_errors
);

   typedef enum logic [1:0] {HDR, PAY, DROP} state_t;

   localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

   state_t      state;
   logic [11:0] beat_cnt;
   logic [31:0] last_keep;
   logic [15:0] opcode;

   logic [15:0] hdr_magic;
   logic [15:0] hdr_len;
   logic [15:0] hdr_op;
   logic        hdr_ok;
   logic        out_free;
   logic        accept;
   logic        last_beat;
   logic [11:0] hdr_beats;
   logic [31:0] hdr_keep;

   assign hdr_magic = s_axis_tdata[15:0];
   assign hdr_len   = s_axis_tdata[31:16];
   assign hdr_op    = s_axis_tdata[47:32];
   assign hdr_ok    = (hdr_magic == MAGIC) && (hdr_len != 16'd0) &&
                      ({1'b0, hdr_len} <= MAX_LEN_W) && !s_axis_tlast;
   assign hdr_beats = {1'b0, hdr_len[15:5]} + {11'd0, |hdr_len[4:0]};
   assign hdr_keep  = (hdr_len[4:0] == 5'd0) ? 32'hFFFF_FFFF
                                             : ((32'h1 << hdr_len[4:0]) - 32'd1);

   // DROP sinks beats regardless of the output stage; ready is held low throughout reset
   assign out_free      = !m_axis_tvalid || m_axis_tready;
   assign s_axis_tready = axi_aresetn && ((state == DROP) || out_free);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign last_beat     = (beat_cnt == 12'd1);

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state         <= HDR;
         beat_cnt      <= '0;
         last_keep     <= '0;
         opcode        <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_terr   <= 1'b0;
         m_axis_tuser  <= '0;
      end else begin
         if (m_axis_tvalid && m_axis_tready)
            m_axis_tvalid <= 1'b0;
         if (accept) begin
            case (state)
               HDR: begin
                  if (hdr_ok) begin
                     opcode    <= hdr_op;
                     beat_cnt  <= hdr_beats;
                     last_keep <= hdr_keep;
                     state     <= PAY;
                  end else if (!s_axis_tlast) begin
                     state <= DROP;
                  end
               end
               PAY: begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= s_axis_tdata;
                  m_axis_tuser  <= opcode;
                  beat_cnt      <= beat_cnt - 12'd1;
                  // The expected final beat always closes the output frame, even if the input runs on
                  if (last_beat) begin
                     m_axis_tlast <= 1'b1;
                     m_axis_terr  <= !s_axis_tlast;
                     m_axis_tkeep <= s_axis_tlast ? last_keep : s_axis_tkeep;
                     state        <= s_axis_tlast ? HDR : DROP;
                  end else begin
                     m_axis_tlast <= s_axis_tlast;
                     m_axis_terr  <= s_axis_tlast;
                     m_axis_tkeep <= s_axis_tkeep;
                     if (s_axis_tlast)
                        state <= HDR;
                  end
               end
               DROP: begin
                  if (s_axis_tlast)
                     state <= HDR;
               end
               default: state <= HDR;
            endcase
         end
      end
   end

`ifdef PCIE_H2C_FRAMER_STATS_EN
   logic [31:0] frames_q;
   logic [31:0] errors_q;
   logic        good_end;
   logic        bad_end;

   assign good_end = accept && (state == PAY) && last_beat && s_axis_tlast;
   assign bad_end  = accept && (((state == HDR) && !hdr_ok) ||
                                ((state == PAY) && (last_beat != s_axis_tlast)));

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         frames_q <= '0;
         errors_q <= '0;
      end else begin
         if (good_end)
            frames_q <= frames_q + 32'd1;
         if (bad_end)
            errors_q <= errors_q + 32'd1;
      end
   end

   assign stat_frames = frames_q;
   assign stat_errors = errors_q;
`else
   assign stat_frames = 32'd0;
   assign stat_errors = 32'd0;
`endif

endmodule

// File: tb/tb_pcie_h2c_framer.sv
// Scoreboard bench for pcie_h2c_framer: random and directed frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_pcie_h2c_framer;

   localparam logic [15:0] MAGIC   = 16'h4B56;
   localparam int          MAX_LEN = 4096;
`ifdef PCIE_H2C_FRAMER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic         axi_aclk;
   logic         axi_aresetn;
   logic [255:0] s_axis_tdata;
   logic [31:0]  s_axis_tkeep;
   logic         s_axis_tlast;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [255:0] m_axis_tdata;
   logic [31:0]  m_axis_tkeep;
   logic         m_axis_tlast;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic [15:0]  m_axis_tuser;
   logic         m_axis_terr;
   logic [31:0]  stat_frames;
   logic [31:0]  stat_errors;

   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         last;
      logic         err;
      logic [15:0]  user;
   } beat_t;

   beat_t exp_q[$];
   beat_t got;
   int    checks = 0;
   int    errors = 0;
   int    exp_frames = 0;
   int    exp_errs = 0;
   int    ready_mode = 0;
   int    pat_idx = 0;
   bit    stalled = 0;

   pcie_h2c_framer #(.MAGIC(MAGIC), .MAX_LEN(MAX_LEN)) dut (
      .axi_aclk      (axi_aclk),
      .axi_aresetn   (axi_aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_terr   (m_axis_terr),
      .stat_frames   (stat_frames),
      .stat_errors   (stat_errors)
   );

   initial axi_aclk = 1'b0;
   always #5 axi_aclk = ~axi_aclk;

   // Sink backpressure: random, always-ready, or the repeating 1,0,0,1 pattern
   always @(posedge axi_aclk) begin
      #1;
      case (ready_mode)
         0: m_axis_tready = ($urandom_range(0, 3) != 0);
         1: m_axis_tready = 1'b1;
         default: begin
            m_axis_tready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
            pat_idx++;
         end
      endcase
   end

   // Monitor: every presented beat must match the scoreboard head; pop on handshake
   always @(negedge axi_aclk) begin
      if (!axi_aresetn) begin
         stalled = 0;
      end else if (m_axis_tvalid) begin
         got = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_terr, m_axis_tuser};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_beat: got data=%h keep=%h last=%0d err=%0d user=%h, required no beat",
                     got.data, got.keep, got.last, got.err, got.user);
         end else begin
            if (got !== exp_q[0]) begin
               errors++;
               $display("[TB] FAIL beat: got data=%h keep=%h last=%0d err=%0d user=%h, required data=%h keep=%h last=%0d err=%0d user=%h",
                        got.data, got.keep, got.last, got.err, got.user,
                        exp_q[0].data, exp_q[0].keep, exp_q[0].last, exp_q[0].err, exp_q[0].user);
            end
            if (m_axis_tready)
               void'(exp_q.pop_front());
         end
         stalled = !m_axis_tready;
      end else begin
         if (stalled) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid_dropped: got tvalid=0 while stalled, required 1");
         end
         stalled = 0;
      end
   end

   task automatic check_output(input string name, input logic [255:0] actual, input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [255:0] data, input logic [31:0] keep, input logic last,
                                 output bit ok);
      bit acc;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = data;
      s_axis_tkeep  = keep;
      s_axis_tlast  = last;
      ok = 0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge axi_aclk);
         acc = s_axis_tready;
         @(posedge axi_aclk);
         #1;
         if (acc) begin
            ok = 1;
            break;
         end
      end
      s_axis_tvalid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL accept_timeout: got no s_axis_tready within 2000 cycles, required acceptance");
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++)
         v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Sends one frame; expected output is derived from header fields and the payload beat count
   task automatic send_frame(input logic [15:0] magic, input logic [15:0] len, input logic [15:0] op,
                             input bit hdr_last, input int p, input int abort_after);
      logic [255:0] data;
      logic [31:0]  keep;
      bit           ok;
      bit           valid;
      int           n;
      int           rem;
      beat_t        e;
      valid = (magic == MAGIC) && (len >= 1) && (int'(len) <= MAX_LEN) && !hdr_last;
      n     = (int'(len) + 31) / 32;
      rem   = int'(len) % 32;
      data  = rand256();
      data[47:0] = {op, len, magic};
      repeat ($urandom_range(0, 2)) begin
         @(posedge axi_aclk);
         #1;
      end
      apply_stimulus(data, 32'hFFFF_FFFF, hdr_last, ok);
      if (!ok)
         return;
      if (!valid)
         exp_errs++;
      for (int i = 1; i <= p; i++) begin
         data = rand256();
         keep = $urandom;
         if ($urandom_range(0, 4) == 0) begin
            @(posedge axi_aclk);
            #1;
         end
         apply_stimulus(data, keep, (i == p), ok);
         if (!ok)
            return;
         if (valid && i <= n) begin
            e.data = data;
            e.user = op;
            if (i == n && i == p) begin
               e.keep = (rem == 0) ? 32'hFFFF_FFFF : ((32'h1 << rem) - 32'h1);
               e.last = 1'b1;
               e.err  = 1'b0;
               exp_frames++;
            end else if (i == n || i == p) begin
               e.keep = keep;
               e.last = 1'b1;
               e.err  = 1'b1;
               exp_errs++;
            end else begin
               e.keep = keep;
               e.last = 1'b0;
               e.err  = 1'b0;
            end
            exp_q.push_back(e);
         end
         if (i == abort_after)
            return;
      end
   endtask

   task automatic drain_and_check(input string name);
      for (int t = 0; t < 5000 && exp_q.size() > 0; t++) begin
         @(posedge axi_aclk);
         #1;
      end
      check_output({name, "_drain"}, 256'(exp_q.size()), 256'd0);
      check_output({name, "_frames"}, 256'(stat_frames), STATS ? 256'(exp_frames) : 256'd0);
      check_output({name, "_errors"}, 256'(stat_errors), STATS ? 256'(exp_errs) : 256'd0);
   endtask

   initial begin
      int cat;
      int len;
      int n;
      logic [15:0] mg;
      bit hl;
      axi_aresetn   = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) @(posedge axi_aclk);
      #1;
      check_output("rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
      check_output("rst_s_tready", 256'(s_axis_tready), 256'd0);
      check_output("rst_m_tdata",  m_axis_tdata, 256'd0);
      check_output("rst_m_tkeep",  256'(m_axis_tkeep), 256'd0);
      check_output("rst_m_tuser",  256'(m_axis_tuser), 256'd0);
      check_output("rst_m_tlast",  256'({m_axis_tlast, m_axis_terr}), 256'd0);
      check_output("rst_stats",    256'({stat_frames, stat_errors}), 256'd0);
      axi_aresetn = 1'b1;

      ready_mode = 1;
      send_frame(MAGIC, 16'd70, 16'h0003, 0, 3, -1);
      drain_and_check("len70");

      send_frame(16'h1234, 16'd64, 16'h0005, 0, 2, -1);
      send_frame(MAGIC, 16'd32, 16'h0006, 0, 1, -1);
      drain_and_check("bad_magic");

      ready_mode = 0;
      send_frame(MAGIC, 16'd96, 16'h0007, 0, 2, -1);
      send_frame(MAGIC, 16'd40, 16'h0008, 0, 2, -1);
      drain_and_check("truncated");

      send_frame(MAGIC, 16'd32, 16'h0009, 0, 3, -1);
      send_frame(MAGIC, 16'd1, 16'h000A, 0, 1, -1);
      drain_and_check("overlong");

      pat_idx    = 0;
      ready_mode = 2;
      send_frame(MAGIC, 16'd320, 16'h000B, 0, 10, -1);
      drain_and_check("stall");

      send_frame(MAGIC, 16'd0, 16'h000C, 1, 0, -1);
      send_frame(MAGIC, 16'(MAX_LEN + 1), 16'h000D, 0, 1, -1);
      send_frame(MAGIC, 16'(MAX_LEN), 16'h000E, 0, MAX_LEN / 32, -1);
      drain_and_check("len_bounds");

      ready_mode = 1;
      send_frame(MAGIC, 16'd128, 16'h000F, 0, 4, 2);
      axi_aresetn = 1'b0;
      #1;
      check_output("reset_m_tvalid", 256'(m_axis_tvalid), 256'd0);
      check_output("reset_s_tready", 256'(s_axis_tready), 256'd0);
      exp_q.delete();
      exp_frames = 0;
      exp_errs   = 0;
      repeat (2) @(posedge axi_aclk);
      #1;
      axi_aresetn = 1'b1;
      send_frame(MAGIC, 16'd50, 16'h0010, 0, 2, -1);
      drain_and_check("after_reset");

      ready_mode = 0;
      for (int f = 0; f < 150; f++) begin
         cat = $urandom_range(0, 9);
         case (cat)
            0: begin
               mg = 16'($urandom);
               if (mg == MAGIC)
                  mg = mg ^ 16'h0001;
               hl = 1'($urandom_range(0, 1));
               send_frame(mg, 16'($urandom_range(1, 300)), 16'($urandom), hl,
                          hl ? 0 : $urandom_range(1, 3), -1);
            end
            1: begin
               len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 65535);
               send_frame(MAGIC, 16'(len), 16'($urandom), 0, $urandom_range(1, 3), -1);
            end
            2: send_frame(MAGIC, 16'($urandom_range(1, 300)), 16'($urandom), 1, 0, -1);
            3: begin
               len = $urandom_range(33, 400);
               n   = (len + 31) / 32;
               send_frame(MAGIC, 16'(len), 16'($urandom), 0, $urandom_range(1, n - 1), -1);
            end
            4: begin
               len = $urandom_range(1, 300);
               n   = (len + 31) / 32;
               send_frame(MAGIC, 16'(len), 16'($urandom), 0, n + $urandom_range(1, 2), -1);
            end
            default: begin
               case ($urandom_range(0, 9))
                  0:       len = MAX_LEN;
                  1:       len = 32 * $urandom_range(1, 8);
                  default: len = $urandom_range(1, 400);
               endcase
               n = (len + 31) / 32;
               send_frame(MAGIC, 16'(len), 16'($urandom), 0, n, -1);
            end
         endcase
      end
      ready_mode = 1;
      drain_and_check("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
